// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: operand/result widths, opcode
// encodings, FSM state enum and the captured-request payload.
package alu_pkg;

    localparam int unsigned NREQ   = 2;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned OPND_W = 4;
    localparam int unsigned RES_W  = 6;

    localparam logic [OP_W-1:0] OP_MUL = 3'b000;
    localparam logic [OP_W-1:0] OP_ADD = 3'b001;
    localparam logic [OP_W-1:0] OP_SUB = 3'b010;
    localparam logic [OP_W-1:0] OP_INC = 3'b011;
    localparam logic [OP_W-1:0] OP_DEC = 3'b100;
    localparam logic [OP_W-1:0] OP_MAX = 3'b101;
    localparam logic [OP_W-1:0] OP_MIN = 3'b110;
    localparam logic [OP_W-1:0] OP_AVG = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
    } op_req_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU requesters + consumer and the arbiter.
//   master : requester/consumer side (drives req_*, rsp_ready)
//   slave  : arbiter side (drives req_ready, rsp_*)
interface alu_arbiter_if;
    import alu_pkg::*;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [OP_W-1:0]   req_op0;
    logic [OP_W-1:0]   req_op1;
    logic [OPND_W-1:0] req_a0;
    logic [OPND_W-1:0] req_b0;
    logic [OPND_W-1:0] req_a1;
    logic [OPND_W-1:0] req_b1;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [RES_W-1:0]  rsp_data;
    logic              rsp_id;

    modport master (
        output req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );

endinterface

// File: rtl/alu_core.sv
// Combinational 4-bit ALU producing a 6-bit result (modulo 64).
//   op  : opcode (OP_MUL..OP_AVG)
//   a,b : unsigned operands
//   res : result
module alu_core
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic [RES_W-1:0]  res
);

    localparam int unsigned SUM_W = OPND_W + 1;

    logic [SUM_W-1:0] sum;

    // Opcode decode; all arithmetic is carried at result width so wrap is modulo 64.
    always_comb begin
        sum = SUM_W'(a) + SUM_W'(b);
        res = '0;
        case (op)
            OP_MUL:  res = RES_W'(a) * RES_W'(b);
            OP_ADD:  res = RES_W'(sum);
            OP_SUB:  res = RES_W'(a) - RES_W'(b);
            OP_INC:  res = RES_W'(a) + RES_W'(1);
            OP_DEC:  res = RES_W'(a) - RES_W'(1);
            OP_MAX:  res = (a > b) ? RES_W'(a) : RES_W'(b);
            OP_MIN:  res = (a < b) ? RES_W'(a) : RES_W'(b);
            OP_AVG:  res = RES_W'(sum >> 1);
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared ALU.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_arbiter_if.slave (requests in, grant strobes, response out)
//   busy       : high whenever the FSM is not in IDLE
//   done_cnt0/1: per-requester accepted-response counters (only with
//                ALU_ARB_STATS_EN defined)
// Parameter MUL_LAT (1..4): EXEC cycles for OP_MUL; other opcodes take one.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned MUL_LAT = 2
)
(
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus,
    output logic          busy
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [7:0]    done_cnt0,
    output logic [7:0]    done_cnt1
`endif
);

    localparam int unsigned CNT_W = 3;

    state_t            state;
    logic              ptr;
    logic [CNT_W-1:0]  cnt;
    op_req_t           cap;
    logic              cap_id;
    logic [RES_W-1:0]  alu_res;
    logic              grant_any;
    logic              grant_id;
    logic [NREQ-1:0]   req_ready_c;
    logic [CNT_W-1:0]  exec_last;

    // Round-robin pick: on contention favour the requester not granted last.
    always_comb begin
        grant_any   = |bus.req_valid;
        grant_id    = 1'b0;
        req_ready_c = '0;
        case (bus.req_valid)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~ptr;
            default: grant_id = 1'b0;
        endcase
        // Gated by rst_n so the strobe is quiet while reset is held.
        if (rst_n && (state == IDLE) && grant_any) begin
            req_ready_c[grant_id] = 1'b1;
        end
    end

    assign bus.req_ready = req_ready_c;

    // Index of the final EXEC cycle for the captured opcode.
    assign exec_last = (cap.op == OP_MUL) ? CNT_W'(MUL_LAT - 1) : '0;

    alu_core u_core (
        .op  (cap.op),
        .a   (cap.a),
        .b   (cap.b),
        .res (alu_res)
    );

    // Arbiter FSM with registered response and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= 1'b1;
            cnt           <= '0;
            cap           <= '0;
            cap_id        <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_id    <= 1'b0;
            busy          <= 1'b0;
`ifdef ALU_ARB_STATS_EN
            done_cnt0     <= '0;
            done_cnt1     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        cap    <= grant_id
                                  ? op_req_t'{op: bus.req_op1, a: bus.req_a1, b: bus.req_b1}
                                  : op_req_t'{op: bus.req_op0, a: bus.req_a0, b: bus.req_b0};
                        cap_id <= grant_id;
                        ptr    <= grant_id;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == exec_last) begin
                        bus.rsp_data  <= alu_res;
                        bus.rsp_id    <= cap_id;
                        bus.rsp_valid <= 1'b1;
                        cnt           <= '0;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        busy          <= 1'b0;
                        state         <= IDLE;
`ifdef ALU_ARB_STATS_EN
                        if (bus.rsp_id) begin
                            done_cnt1 <= done_cnt1 + 8'd1;
                        end else begin
                            done_cnt0 <= done_cnt0 + 8'd1;
                        end
`endif
                    end
                end
                default: begin
                    bus.rsp_valid <= 1'b0;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter (MUL_LAT = 2).
// Optional counter checks compile in when ALU_ARB_STATS_EN is defined.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        busy;
`ifdef ALU_ARB_STATS_EN
    logic [7:0]  done_cnt0;
    logic [7:0]  done_cnt1;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc    = 0;

    // Hand-computed sweep results: a=0,b=15 and a=15,b=0, indexed by opcode.
    int unsigned exp_a0b15 [8] = '{0, 15, 49, 1, 63, 15, 0, 7};
    int unsigned exp_a15b0 [8] = '{0, 15, 15, 16, 14, 15, 0, 7};

    alu_arbiter_if bus();

    alu_arbiter #(.MUL_LAT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
`ifdef ALU_ARB_STATS_EN
        ,
        .done_cnt0 (done_cnt0),
        .done_cnt1 (done_cnt1)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        if (id == 1) begin
            bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b;
        end else begin
            bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b;
        end
        bus.req_valid[id] = 1'b1;
    endtask

    task automatic wait_rsp(output int unsigned at_cyc);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("rsp_timeout", 32'(seen), 32'd1);
        at_cyc = cyc;
    endtask

    // Single request, drop it after the grant, scramble inputs, check the response.
    task automatic do_txn(input int id, input logic [2:0] op, input logic [3:0] a,
                          input logic [3:0] b, input int unsigned exp);
        logic        granted;
        int unsigned t;
        set_req(id, op, a, b);
        #1;
        granted = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.req_ready[id] === 1'b1) begin
                granted = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        check($sformatf("grant_r%0d", id), 32'(granted), 32'd1);
        @(negedge clk);
        bus.req_valid = 2'b00;
        bus.req_op0 = ~bus.req_op0; bus.req_a0 = ~bus.req_a0; bus.req_b0 = ~bus.req_b0;
        bus.req_op1 = ~bus.req_op1; bus.req_a1 = ~bus.req_a1; bus.req_b1 = ~bus.req_b1;
        wait_rsp(t);
        check($sformatf("txn_data_op%0d_r%0d", op, id), 32'(bus.rsp_data), 32'(exp));
        check($sformatf("txn_id_op%0d", op), 32'(bus.rsp_id), 32'(id));
    endtask

    initial begin
        int unsigned t;
        int unsigned tprev;
        int unsigned spurious;

        // Reset with both requests already asserted.
        rst_n = 1'b0;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 2'b11;
        bus.req_op0 = OP_ADD; bus.req_a0 = 4'd7; bus.req_b0 = 4'd9;
        bus.req_op1 = OP_SUB; bus.req_a1 = 4'd3; bus.req_b1 = 4'd5;
        repeat (2) @(negedge clk);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_busy",      32'(busy),          32'd0);
        check("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
        check("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
`ifdef ALU_ARB_STATS_EN
        check("rst_cnt0", 32'(done_cnt0), 32'd0);
        check("rst_cnt1", 32'(done_cnt1), 32'd0);
`endif

        // Continuous contention: strict alternation starting at requester 0.
        rst_n = 1'b1;
        #1;
        check("first_contention_ready", 32'(bus.req_ready), 32'd1);
        tprev = 0;
        for (int k = 0; k < 6; k++) begin
            wait_rsp(t);
            check($sformatf("alt_id_%0d", k),   32'(bus.rsp_id),   32'(k % 2));
            check($sformatf("alt_data_%0d", k), 32'(bus.rsp_data), (k % 2 == 1) ? 32'd62 : 32'd16);
            if (k > 0) check($sformatf("alt_spacing_%0d", k), t - tprev, 32'd3);
            tprev = t;
            if (k == 5) bus.req_valid = 2'b00;
        end
        repeat (2) @(negedge clk);
        check("alt_idle_busy",  32'(busy),          32'd0);
        check("alt_idle_valid", 32'(bus.rsp_valid), 32'd0);

        // Multiply 15*15 wraps to 33, MUL_LAT=2; then stall in RESP for 5 cycles.
        bus.rsp_ready = 1'b0;
        set_req(0, OP_MUL, 4'd15, 4'd15);
        #1;
        check("mul_grant", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 2'b00;
        bus.req_op0 = OP_ADD; bus.req_a0 = 4'd0; bus.req_b0 = 4'd0;
        #1;
        check("mul_exec1_valid", 32'(bus.rsp_valid), 32'd0);
        check("mul_exec1_busy",  32'(busy),          32'd1);
        check("mul_exec1_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        check("mul_exec2_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        check("mul_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("mul_rsp_data",  32'(bus.rsp_data),  32'd33);
        check("mul_rsp_id",    32'(bus.rsp_id),    32'd0);
        bus.req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("stall_valid_%0d", i), 32'(bus.rsp_valid), 32'd1);
            check($sformatf("stall_data_%0d", i),  32'(bus.rsp_data),  32'd33);
            check($sformatf("stall_id_%0d", i),    32'(bus.rsp_id),    32'd0);
            check($sformatf("stall_ready_%0d", i), 32'(bus.req_ready), 32'd0);
            check($sformatf("stall_busy_%0d", i),  32'(busy),          32'd1);
            @(negedge clk);
        end
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("stall_release_valid", 32'(bus.rsp_valid), 32'd0);
        check("stall_release_busy",  32'(busy),          32'd0);

        // Reset while a multiply is in EXEC.
        set_req(0, OP_MUL, 4'd15, 4'd15);
        @(negedge clk);
        bus.req_valid = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(bus.rsp_valid), 32'd0);
        check("midrst_busy",  32'(busy),          32'd0);
        check("midrst_state", 32'(dut.state),     32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) spurious++;
        end
        check("midrst_no_rsp", spurious, 32'd0);
        check("midrst_busy_after", 32'(busy), 32'd0);
        set_req(0, OP_ADD, 4'd7, 4'd9);
        set_req(1, OP_SUB, 4'd3, 4'd5);
        #1;
        check("midrst_ptr_reset", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 2'b00;
        wait_rsp(t);
        check("midrst_new_data", 32'(bus.rsp_data), 32'd16);
        check("midrst_new_id",   32'(bus.rsp_id),   32'd0);
        @(negedge clk);

        // Opcode sweep with boundary operands, alternating requesters.
        for (int o = 0; o < 8; o++) begin
            do_txn(0, 3'(o), 4'd0, 4'd15, exp_a0b15[o]);
            @(negedge clk);
            do_txn(1, 3'(o), 4'd15, 4'd0, exp_a15b0[o]);
            @(negedge clk);
        end

`ifdef ALU_ARB_STATS_EN
        // Counter wrap: 256 accepted responses for requester 1 only.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 255; i++) begin
            do_txn(1, OP_ADD, 4'd1, 4'd2, 3);
            @(negedge clk);
        end
        check("cnt1_255", 32'(done_cnt1), 32'd255);
        do_txn(1, OP_ADD, 4'd1, 4'd2, 3);
        @(negedge clk);
        check("cnt1_wrap", 32'(done_cnt1), 32'd0);
        check("cnt0_zero", 32'(done_cnt0), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
